ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter N, default 4, data word width in bits.
REQ-002 Parameter SIZE, default 32, RAM depth in words; ADDRW = $clog2(SIZE).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a load burst; sampled in IDLE only.
REQ-006 len  input  ADDRW+1  number of words to load (legal 1..SIZE); sampled with start.
REQ-007 in_valid  input  1  source has a word on in_data.
REQ-008 in_data  input  N  word to be written.
REQ-009 in_ready  output  1  loader accepts a word this cycle.
REQ-010 wen  output  1  RAM write enable.
REQ-011 waddr  output  ADDRW  RAM write address.
REQ-012 wdata  output  N  RAM write data.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at burst completion.
REQ-015 count  output  ADDRW+1  words written in the current or most recent burst.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD and DONE, plus CLEAR when RAM_LOADER_CLEAR_EN is defined.
REQ-018 IDLE: start with 1<=len<=SIZE SHALL latch len, zero the address and count, and go to LOAD on the next cycle.
REQ-019 IDLE: start with len==0 or len>SIZE SHALL set err, remain in IDLE and produce no write.
REQ-020 in_ready SHALL be combinational from registered state: 1 only in LOAD with count<latched len.
REQ-021 A transfer occurs when in_valid&&in_ready; in_valid outside LOAD SHALL be ignored.
REQ-022 Each transfer SHALL produce wen=1, waddr=current address, wdata=in_data exactly one cycle later (registered, latency 1).
REQ-023 The address and count SHALL increment by 1 per transfer; addresses are contiguous from 0; no wrap occurs because len<=SIZE.
REQ-024 The transfer with count==len-1 SHALL move the FSM to DONE; the DONE cycle coincides with the last wen, and done=1 for exactly that cycle.
REQ-025 DONE SHALL return to IDLE unconditionally after one cycle; count SHALL hold its final value until the next accepted start.
REQ-026 start asserted in LOAD, DONE or CLEAR SHALL be ignored and SHALL set err.
REQ-027 wen SHALL be 0 in every cycle not described by REQ-022 or REQ-031.

Reset
REQ-028 When reset is high at a clock edge, the block SHALL force in_ready, wen, waddr, wdata, done, count and err to 0 and abort any burst in progress.
REQ-029 After reset, the FSM SHALL enter IDLE (busy=0), or CLEAR when RAM_LOADER_CLEAR_EN is defined.
REQ-030 err SHALL be cleared only by reset.

Configuration
REQ-031 With RAM_LOADER_CLEAR_EN defined: CLEAR SHALL write wdata=0 to addresses 0..SIZE-1, one per cycle with wen=1, busy=1 and in_ready=0, then enter IDLE; without the macro, CLEAR SHALL not exist and reset SHALL go directly to IDLE.

Structure
REQ-032 A shared package ram_pkg SHALL hold SIZE, ADDRW and the state enum typedef; the matching RAM reader SHALL use the same package.
REQ-033 Registered state, address, count and write outputs SHALL be built from the existing register sub-module (clk, reset, enable, d, q).

Verification
REQ-034 Start with len=4, then in_data 3,9,1,7 sent back-to-back -> wen at addresses 0..3 with matching data, each one cycle after its transfer; done on the address-3 write; count=4.
REQ-035 len=3 with in_valid held low on alternate cycles -> writes occur only on handshake cycles, at addresses 0,1,2; in_ready=0 after the third transfer.
REQ-036 len=32 -> addresses 0..31, count=32, no wrap, in_ready low after the 32nd transfer.
REQ-037 start with len=0, then start with len=33 -> err=1, busy=0, no wen; a later start with len=2 still loads correctly.
REQ-038 Reset asserted after 2 transfers of a len=5 burst -> all outputs 0 on the next cycle; a new start writes from address 0.
REQ-039 With RAM_LOADER_CLEAR_EN defined, release reset -> 32 consecutive wen cycles with wdata=0 at addresses 0..31, busy=1, then IDLE; start during CLEAR sets err.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared RAM geometry and loader state encoding; the reader uses the same package.
// RAM_LOADER_CLEAR_EN adds the post-reset CLEAR state.
package ram_pkg;

    localparam int unsigned SIZE  = 32;
    localparam int unsigned ADDRW = $clog2(SIZE);

`ifdef RAM_LOADER_CLEAR_EN
    typedef enum logic [1:0] {StIdle, StLoad, StDone, StClear} state_e;
    localparam state_e ResetState = StClear;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;
    localparam state_e ResetState = StIdle;
`endif

endpackage

// File: rtl/ram_loader_reg.sv
// Generic enabled register with synchronous active-high reset to a parameterised value.
module ram_loader_reg #(
    parameter int unsigned W        = 1,
    parameter logic [W-1:0] ResetVal = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= ResetVal;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Streams len words from a valid/ready source into a RAM write port, addresses from 0.
// Define RAM_LOADER_CLEAR_EN to zero the whole RAM after every reset.
module ram_loader #(
    parameter int unsigned N     = 4,
    parameter int unsigned SIZE  = ram_pkg::SIZE,
    localparam int unsigned ADDRW = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ADDRW:0]   len,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic             wen,
    output logic [ADDRW-1:0] waddr,
    output logic [N-1:0]     wdata,
    output logic             busy,
    output logic             done,
    output logic [ADDRW:0]   count,
    output logic             err
);

    localparam logic [ADDRW:0] LenMax = (ADDRW+1)'(SIZE);
`ifdef RAM_LOADER_CLEAR_EN
    localparam logic [ADDRW-1:0] LastAddr = ADDRW'(SIZE - 1);
`endif

    ram_pkg::state_e  state_q, state_d;
    logic [1:0]       state_raw;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [ADDRW:0]   count_q, count_d;
    logic [ADDRW:0]   len_q, len_d;
    logic             err_q, err_d;
    logic             wen_q, wen_d;
    logic [ADDRW-1:0] waddr_q, waddr_d;
    logic [N-1:0]     wdata_q, wdata_d;
    logic             xfer;

    assign state_q  = ram_pkg::state_e'(state_raw);
    assign in_ready = (state_q == ram_pkg::StLoad) && (count_q < len_q);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        len_d   = len_q;
        err_d   = err_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        // start is only meaningful in IDLE; anywhere else it is a protocol error
        if (start && (state_q != ram_pkg::StIdle)) begin
            err_d = 1'b1;
        end
        case (state_q)
            ram_pkg::StIdle: begin
                if (start) begin
                    if ((len != '0) && (len <= LenMax)) begin
                        len_d   = len;
                        addr_d  = '0;
                        count_d = '0;
                        state_d = ram_pkg::StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ram_pkg::StLoad: begin
                if (xfer) begin
                    wen_d   = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = in_data;
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == len_q - 1'b1) begin
                        state_d = ram_pkg::StDone;
                    end
                end
            end
            ram_pkg::StDone: begin
                state_d = ram_pkg::StIdle;
            end
`ifdef RAM_LOADER_CLEAR_EN
            ram_pkg::StClear: begin
                // Stay until the last zero write is visible so busy covers every clear write
                if (wen_q && (waddr_q == LastAddr)) begin
                    state_d = ram_pkg::StIdle;
                end else begin
                    wen_d   = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = '0;
                    addr_d  = addr_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = ram_pkg::StIdle;
            end
        endcase
    end

    ram_loader_reg #(.W(2), .ResetVal(ram_pkg::ResetState)) u_state_reg (
        .clk(clk), .reset(reset), .enable(1'b1), .d(state_d), .q(state_raw)
    );
    ram_loader_reg #(.W(ADDRW)) u_addr_reg (
        .clk(clk), .reset(reset), .enable(1'b1), .d(addr_d), .q(addr_q)
    );
    ram_loader_reg #(.W(ADDRW+1)) u_count_reg (
        .clk(clk), .reset(reset), .enable(1'b1), .d(count_d), .q(count_q)
    );
    ram_loader_reg #(.W(ADDRW+1)) u_len_reg (
        .clk(clk), .reset(reset), .enable(1'b1), .d(len_d), .q(len_q)
    );
    ram_loader_reg #(.W(1)) u_err_reg (
        .clk(clk), .reset(reset), .enable(1'b1), .d(err_d), .q(err_q)
    );
    ram_loader_reg #(.W(1)) u_wen_reg (
        .clk(clk), .reset(reset), .enable(1'b1), .d(wen_d), .q(wen_q)
    );
    ram_loader_reg #(.W(ADDRW)) u_waddr_reg (
        .clk(clk), .reset(reset), .enable(wen_d), .d(waddr_d), .q(waddr_q)
    );
    ram_loader_reg #(.W(N)) u_wdata_reg (
        .clk(clk), .reset(reset), .enable(wen_d), .d(wdata_d), .q(wdata_q)
    );

    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign busy  = (state_q != ram_pkg::StIdle);
    assign done  = (state_q == ram_pkg::StDone);
    assign count = count_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ram_loader.sv
// Randomised self-checking bench for ram_loader against a word-level reference model.
// Honours RAM_LOADER_CLEAR_EN the same way as the design.
module tb_ram_loader;

    localparam int unsigned N    = 4;
    localparam int unsigned SIZE = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned VW   = 1 + 1 + AW + N + 1 + 1 + (AW + 1) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          in_valid = 1'b0;
    logic [N-1:0]  in_data = '0;
    logic          in_ready, wen, busy, done, err;
    logic [AW-1:0] waddr;
    logic [N-1:0]  wdata;
    logic [AW:0]   count;
    logic [VW-1:0] act_vec;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ram_loader #(.N(N), .SIZE(SIZE)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .wen(wen), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .count(count), .err(err)
    );

    assign act_vec = {in_ready, wen, waddr, wdata, busy, done, count, err};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference model: what the loader should be showing after each clock edge
    typedef enum {MIdle, MLoad, MDone, MClear} mmode_e;
    mmode_e        m_mode = MIdle;
    int            m_len = 0;
    int            m_cnt = 0;
    int            m_clr = 0;
    logic          m_err = 1'b0;
    logic          m_wen = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [N-1:0]  m_wdata = '0;

    task automatic model_step();
        bit hs;
        if (reset) begin
`ifdef RAM_LOADER_CLEAR_EN
            m_mode = MClear;
`else
            m_mode = MIdle;
`endif
            m_len = 0; m_cnt = 0; m_clr = 0;
            m_err = 1'b0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
            return;
        end
        hs = (m_mode == MLoad) && (m_cnt < m_len) && in_valid;
        m_wen = 1'b0;
        if (start && m_mode != MIdle) m_err = 1'b1;
        case (m_mode)
            MIdle: if (start) begin
                if (int'(len) >= 1 && int'(len) <= SIZE) begin
                    m_len = int'(len); m_cnt = 0; m_mode = MLoad;
                end else begin
                    m_err = 1'b1;
                end
            end
            MLoad: if (hs) begin
                m_wen = 1'b1; m_waddr = AW'(m_cnt); m_wdata = in_data;
                m_cnt++;
                if (m_cnt == m_len) m_mode = MDone;
            end
            MDone: m_mode = MIdle;
            MClear: begin
                if (m_clr == SIZE) m_mode = MIdle;
                else begin
                    m_wen = 1'b1; m_waddr = AW'(m_clr); m_wdata = '0; m_clr++;
                end
            end
        endcase
    endtask

    function automatic logic [VW-1:0] expected_vec();
        logic rdy;
        rdy = (m_mode == MLoad) && (m_cnt < m_len);
        return {rdy, m_wen, m_waddr, m_wdata, m_mode != MIdle, m_mode == MDone,
                (AW+1)'(m_cnt), m_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic pulse_start(input int l);
        start = 1'b1; len = (AW+1)'(l);
        tick();
        start = 1'b0;
        checks++;
        if (act_vec !== expected_vec()) begin
            errors++;
            $display("FAIL start cyc=%0d act=%h exp=%h", cyc, act_vec, expected_vec());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({in_ready, wen, waddr, wdata, done, count, err} !== '0) begin
            errors++;
            $display("FAIL reset_zero act=%h exp=0", act_vec);
        end
        reset = 1'b0;
        for (int i = 0; i < 100 && m_mode != MIdle; i++) begin
            tick();
            checks++;
            if (act_vec !== expected_vec()) begin
                errors++;
                $display("FAIL reset cyc=%0d act=%h exp=%h", cyc, act_vec, expected_vec());
            end
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] words [4];
        logic [AW+N-1:0] seen [$];
        words[0] = 4'd3; words[1] = 4'd9; words[2] = 4'd1; words[3] = 4'd7;
        test_reset();
        pulse_start(4);
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 4);
            in_data  = (i < 4) ? words[i] : 4'h0;
            tick();
            checks++;
            if (act_vec !== expected_vec()) begin
                errors++;
                $display("FAIL basic cyc=%0d act=%h exp=%h", cyc, act_vec, expected_vec());
            end
            if (wen) seen.push_back({waddr, wdata});
            if (done && !(wen && waddr == 5'd3)) begin
                errors++;
                $display("FAIL basic_done_pos act=wen%0b/addr%0d exp=wen1/addr3", wen, waddr);
            end
        end
        checks++;
        if (seen.size() != 4) begin
            errors++;
            $display("FAIL basic_writes act=%0d exp=4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seen[i] !== {AW'(i), words[i]}) begin
                    errors++;
                    $display("FAIL basic_word%0d act=%h exp=%h", i, seen[i], {AW'(i), words[i]});
                end
            end
        end
        checks++;
        if (count !== 6'd4) begin
            errors++;
            $display("FAIL basic_count act=%0d exp=4", count);
        end
    endtask

    task automatic test_gaps();
        test_reset();
        pulse_start(3);
        for (int i = 0; i < 9; i++) begin
            in_valid = i[0];
            in_data  = N'($urandom);
            tick();
            checks++;
            if (act_vec !== expected_vec()) begin
                errors++;
                $display("FAIL gaps cyc=%0d act=%h exp=%h", cyc, act_vec, expected_vec());
            end
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || count !== 6'd3) begin
            errors++;
            $display("FAIL gaps_end act=rdy%0b/cnt%0d exp=rdy0/cnt3", in_ready, count);
        end
    endtask

    task automatic test_full();
        test_reset();
        pulse_start(SIZE);
        for (int i = 0; i < SIZE + 4; i++) begin
            in_valid = 1'b1;
            in_data  = N'($urandom);
            tick();
            checks++;
            if (act_vec !== expected_vec()) begin
                errors++;
                $display("FAIL full cyc=%0d act=%h exp=%h", cyc, act_vec, expected_vec());
            end
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 6'd32 || in_ready !== 1'b0 || waddr !== 5'd31) begin
            errors++;
            $display("FAIL full_end act=cnt%0d/rdy%0b/addr%0d exp=cnt32/rdy0/addr31",
                     count, in_ready, waddr);
        end
    endtask

    task automatic test_bad_len();
        test_reset();
        pulse_start(0);
        pulse_start(33);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || wen !== 1'b0) begin
            errors++;
            $display("FAIL bad_len act=err%0b/busy%0b/wen%0b exp=err1/busy0/wen0", err, busy, wen);
        end
        pulse_start(2);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = N'($urandom);
            tick();
            checks++;
            if (act_vec !== expected_vec()) begin
                errors++;
                $display("FAIL bad_len_load cyc=%0d act=%h exp=%h", cyc, act_vec, expected_vec());
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        test_reset();
        pulse_start(5);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i < 2);
            start    = (i == 2);
            in_data  = N'($urandom);
            tick();
            checks++;
            if (act_vec !== expected_vec()) begin
                errors++;
                $display("FAIL mid cyc=%0d act=%h exp=%h", cyc, act_vec, expected_vec());
            end
        end
        start = 1'b0; in_valid = 1'b1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL mid_start_err act=%0b exp=1", err);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({in_ready, wen, waddr, wdata, done, count, err} !== '0) begin
            errors++;
            $display("FAIL mid_abort act=%h exp=0", act_vec);
        end
        in_valid = 1'b0;
        test_reset();
        pulse_start(2);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = N'($urandom);
            tick();
            checks++;
            if (act_vec !== expected_vec()) begin
                errors++;
                $display("FAIL mid_reload cyc=%0d act=%h exp=%h", cyc, act_vec, expected_vec());
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        int l;
        test_reset();
        for (int b = 0; b < 24; b++) begin
            if ($urandom_range(7) == 0) l = ($urandom_range(1) == 0) ? 0 : $urandom_range(63, 33);
            else l = $urandom_range(SIZE, 1);
            pulse_start(l);
            for (int i = 0; i < 400 && m_mode != MIdle; i++) begin
                in_valid = ($urandom_range(3) != 0);
                in_data  = N'($urandom);
                start    = (m_mode == MLoad) && ($urandom_range(31) == 0);
                len      = (AW+1)'($urandom);
                tick();
                checks++;
                if (act_vec !== expected_vec()) begin
                    errors++;
                    $display("FAIL random b=%0d cyc=%0d act=%h exp=%h",
                             b, cyc, act_vec, expected_vec());
                end
            end
            start = 1'b0; in_valid = 1'b0;
        end
    endtask

`ifdef RAM_LOADER_CLEAR_EN
    task automatic test_clear();
        int nwen = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100 && m_mode != MIdle; i++) begin
            start = (i == 6);
            len   = 6'd4;
            tick();
            if (wen) nwen++;
            checks++;
            if (act_vec !== expected_vec()) begin
                errors++;
                $display("FAIL clear cyc=%0d act=%h exp=%h", cyc, act_vec, expected_vec());
            end
        end
        start = 1'b0;
        checks++;
        if (nwen != SIZE || err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_end act=wen%0d/err%0b/busy%0b exp=wen32/err1/busy0",
                     nwen, err, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef RAM_LOADER_CLEAR_EN
        test_clear();
`endif
        test_basic();
        test_gaps();
        test_full();
        test_bad_len();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
